// File: rtl/shift_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : shift_load_controller
// Purpose  : Loads a parallel word into an external SIPO shift register one
//            bit per cycle, then captures and returns the register contents.
//            Define SHIFT_LOAD_CHECK_EN to build the capture-time compare
//            that drives mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module shift_load_controller #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   input  logic             abort,
   output logic             sr_clr,
   output logic             sr_shift_en,
   output logic             sr_data_in,
   input  logic [WIDTH-1:0] sr_data_out,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             mismatch
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_SHIFT   = 3'd2,
      S_SETTLE  = 3'd3,
      S_CAPTURE = 3'd4
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_word;

   logic [WIDTH-1:0] w_rev;
   logic [WIDTH-1:0] w_ord;
   logic [CW-1:0]    w_sel_k;
   logic             w_bit;

   // w_ord is the word in transmit order: bit k of the sequence is w_ord[WIDTH-1-k],
   // which is also the value the register must hold after the last shift.
   always_comb begin
      w_rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_rev[i] = r_word[WIDTH-1-i];
      end
      w_ord   = (MSB_FIRST != 0) ? r_word : w_rev;
      w_sel_k = (r_state == S_SHIFT) ? (r_cnt + CW'(1)) : '0;
      w_bit   = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_sel_k == CW'(i)) begin
            w_bit = w_ord[WIDTH-1-i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_word      <= '0;
         req_ready   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         sr_clr      <= 1'b0;
         sr_shift_en <= 1'b0;
         sr_data_in  <= 1'b0;
         result      <= '0;
`ifdef SHIFT_LOAD_CHECK_EN
         mismatch    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (r_state == S_IDLE) begin
            sr_clr <= 1'b0;
            if (req_valid) begin
               r_word    <= req_data;
               r_cnt     <= '0;
               r_state   <= S_CLEAR;
               sr_clr    <= 1'b1;
               req_ready <= 1'b0;
               busy      <= 1'b1;
`ifdef SHIFT_LOAD_CHECK_EN
               mismatch  <= 1'b0;
`endif
            end
         end else if (abort) begin
            // Cancel leaves the register cleared so a partial word never lingers.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            sr_clr      <= 1'b1;
            sr_shift_en <= 1'b0;
            sr_data_in  <= 1'b0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
         end else begin
            case (r_state)
               S_CLEAR: begin
                  sr_clr      <= 1'b0;
                  r_cnt       <= '0;
                  sr_shift_en <= 1'b1;
                  sr_data_in  <= w_bit;
                  r_state     <= S_SHIFT;
               end
               S_SHIFT: begin
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == CW'(WIDTH - 1)) begin
                     sr_shift_en <= 1'b0;
                     sr_data_in  <= 1'b0;
                     r_state     <= S_SETTLE;
                  end else begin
                     sr_data_in  <= w_bit;
                  end
               end
               S_SETTLE: begin
                  r_state <= S_CAPTURE;
               end
               S_CAPTURE: begin
                  result    <= sr_data_out;
                  done      <= 1'b1;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
`ifdef SHIFT_LOAD_CHECK_EN
                  mismatch  <= (sr_data_out != w_ord);
`endif
               end
               default: begin
                  r_state   <= S_IDLE;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

`ifndef SHIFT_LOAD_CHECK_EN
   assign mismatch = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_load_controller
// Purpose  : Directed self-checking bench; instance a is MSB-first, b is
//            LSB-first, each driving a behavioural 8-bit SIPO register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_load_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       abort = 1'b0;
   logic       stuck = 1'b0;

   logic       req_valid_a = 1'b0, req_valid_b = 1'b0;
   logic [7:0] req_data_a = '0, req_data_b = '0;
   logic       req_ready_a, req_ready_b;
   logic       sr_clr_a, sr_clr_b, sr_shift_en_a, sr_shift_en_b;
   logic       sr_data_in_a, sr_data_in_b;
   logic [7:0] sr_data_out_a, sr_data_out_b;
   logic       busy_a, busy_b, done_a, done_b, mismatch_a, mismatch_b;
   logic [7:0] result_a, result_b;
   logic [7:0] q_a = '0, q_b = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sr_clr_a) q_a <= '0;
      else if (sr_shift_en_a) q_a <= {q_a[6:0], sr_data_in_a};
      if (sr_clr_b) q_b <= '0;
      else if (sr_shift_en_b) q_b <= {q_b[6:0], sr_data_in_b};
   end
   assign sr_data_out_a = stuck ? (q_a & 8'hFE) : q_a;
   assign sr_data_out_b = q_b;

   shift_load_controller #(.WIDTH(8), .MSB_FIRST(1)) u_dut_a (
      .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
      .req_data(req_data_a), .abort(abort), .sr_clr(sr_clr_a),
      .sr_shift_en(sr_shift_en_a), .sr_data_in(sr_data_in_a),
      .sr_data_out(sr_data_out_a), .busy(busy_a), .done(done_a),
      .result(result_a), .mismatch(mismatch_a)
   );

   shift_load_controller #(.WIDTH(8), .MSB_FIRST(0)) u_dut_b (
      .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_data(req_data_b), .abort(abort), .sr_clr(sr_clr_b),
      .sr_shift_en(sr_shift_en_b), .sr_data_in(sr_data_in_b),
      .sr_data_out(sr_data_out_b), .busy(busy_b), .done(done_b),
      .result(result_b), .mismatch(mismatch_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of ticks until done is seen, or -1 after 40 ticks.
   task automatic wait_done(input bit sel, output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if ((sel ? done_b : done_a) === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({req_ready_a, busy_a, done_a, sr_clr_a, sr_shift_en_a, sr_data_in_a, mismatch_a} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_ctrl_a: got %b expected 1000000",
                  {req_ready_a, busy_a, done_a, sr_clr_a, sr_shift_en_a, sr_data_in_a, mismatch_a});
      end
      checks++;
      if (result_a !== 8'h00 || result_b !== 8'h00 || req_ready_b !== 1'b1) begin
         errors++;
         $display("FAIL reset_result: got a=%h b=%h rdy_b=%b expected 00 00 1", result_a, result_b, req_ready_b);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_msb_first();
      logic [7:0] w;
      w = 8'hA5;
      req_valid_a = 1'b1;
      req_data_a  = w;
      checks++;
      if (req_ready_a !== 1'b1) begin
         errors++;
         $display("FAIL msb_ready: got %b expected 1", req_ready_a);
      end
      tick();
      req_valid_a = 1'b0;
      checks++;
      if ({sr_clr_a, sr_shift_en_a, busy_a} !== 3'b101) begin
         errors++;
         $display("FAIL msb_clear: got %b expected 101", {sr_clr_a, sr_shift_en_a, busy_a});
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if ({sr_clr_a, sr_shift_en_a, sr_data_in_a} !== {1'b0, 1'b1, w[7-k]}) begin
            errors++;
            $display("FAIL msb_shift[%0d]: got %b expected %b", k,
                     {sr_clr_a, sr_shift_en_a, sr_data_in_a}, {1'b0, 1'b1, w[7-k]});
         end
      end
      tick();
      checks++;
      if ({sr_clr_a, sr_shift_en_a, sr_data_in_a, busy_a} !== 4'b0001) begin
         errors++;
         $display("FAIL msb_settle: got %b expected 0001", {sr_clr_a, sr_shift_en_a, sr_data_in_a, busy_a});
      end
      tick();
      checks++;
      if ({done_a, busy_a} !== 2'b01) begin
         errors++;
         $display("FAIL msb_capture: got %b expected 01", {done_a, busy_a});
      end
      tick();
      checks++;
      if ({done_a, busy_a, req_ready_a, mismatch_a} !== 4'b1010 || result_a !== 8'hA5) begin
         errors++;
         $display("FAIL msb_done: got flags %b result %h expected 1010 a5",
                  {done_a, busy_a, req_ready_a, mismatch_a}, result_a);
      end
      tick();
      checks++;
      if (done_a !== 1'b0) begin
         errors++;
         $display("FAIL msb_done_pulse: got %b expected 0", done_a);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] w;
      int cyc;
      w = 8'h01;
      req_valid_b = 1'b1;
      req_data_b  = w;
      tick();
      req_valid_b = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if ({sr_shift_en_b, sr_data_in_b} !== {1'b1, w[k]}) begin
            errors++;
            $display("FAIL lsb_shift[%0d]: got %b expected %b", k, {sr_shift_en_b, sr_data_in_b}, {1'b1, w[k]});
         end
      end
      wait_done(1'b1, cyc);
      checks++;
      if (cyc !== 3 || result_b !== 8'h80) begin
         errors++;
         $display("FAIL lsb_done: got cycles %0d result %h expected 3 80", cyc, result_b);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      req_valid_a = 1'b1;
      req_data_a  = 8'h3C;
      tick();
      req_data_a  = 8'hFF;
      wait_done(1'b0, cyc);
      checks++;
      if (cyc !== 11 || result_a !== 8'h3C) begin
         errors++;
         $display("FAIL b2b_first: got cycles %0d result %h expected 11 3c", cyc, result_a);
      end
      tick();
      req_valid_a = 1'b0;
      checks++;
      if ({busy_a, sr_clr_a} !== 2'b11) begin
         errors++;
         $display("FAIL b2b_accept: got %b expected 11", {busy_a, sr_clr_a});
      end
      wait_done(1'b0, cyc);
      checks++;
      if (cyc !== 11 || result_a !== 8'hFF) begin
         errors++;
         $display("FAIL b2b_second: got cycles %0d result %h expected 11 ff", cyc, result_a);
      end
   endtask

   task automatic test_abort();
      int cyc;
      req_valid_a = 1'b1;
      req_data_a  = 8'h5A;
      tick();
      req_valid_a = 1'b0;
      tick();
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({req_ready_a, busy_a, sr_clr_a, sr_shift_en_a, done_a} !== 5'b10100) begin
         errors++;
         $display("FAIL abort_idle: got %b expected 10100",
                  {req_ready_a, busy_a, sr_clr_a, sr_shift_en_a, done_a});
      end
      wait_done(1'b0, cyc);
      checks++;
      if (cyc !== -1 || result_a !== 8'hFF) begin
         errors++;
         $display("FAIL abort_no_done: got cycles %0d result %h expected -1 ff", cyc, result_a);
      end
      req_valid_a = 1'b1;
      tick();
      req_valid_a = 1'b0;
      wait_done(1'b0, cyc);
      checks++;
      if (cyc !== 11 || result_a !== 8'h5A) begin
         errors++;
         $display("FAIL abort_retry: got cycles %0d result %h expected 11 5a", cyc, result_a);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({sr_clr_a, busy_a, req_ready_a} !== 3'b001) begin
         errors++;
         $display("FAIL abort_in_idle: got %b expected 001", {sr_clr_a, busy_a, req_ready_a});
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      req_valid_a = 1'b1;
      req_data_a  = 8'hC3;
      tick();
      req_valid_a = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({req_ready_a, busy_a, done_a, sr_clr_a, sr_shift_en_a, sr_data_in_a, mismatch_a} !== 7'b1000000
          || result_a !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid: got flags %b result %h expected 1000000 00",
                  {req_ready_a, busy_a, done_a, sr_clr_a, sr_shift_en_a, sr_data_in_a, mismatch_a}, result_a);
      end
      reset = 1'b0;
      tick();
      checks++;
      if ({sr_clr_a, busy_a} !== 2'b00) begin
         errors++;
         $display("FAIL reset_no_clr: got %b expected 00", {sr_clr_a, busy_a});
      end
      req_valid_a = 1'b1;
      req_data_a  = 8'h12;
      tick();
      req_data_a  = 8'h34;
      for (int i = 0; i < 9; i++) tick();
      req_valid_a = 1'b0;
      wait_done(1'b0, cyc);
      checks++;
      if (cyc !== 2 || result_a !== 8'h12) begin
         errors++;
         $display("FAIL busy_ignore: got cycles %0d result %h expected 2 12", cyc, result_a);
      end
      wait_done(1'b0, cyc);
      checks++;
      if (cyc !== -1 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL busy_no_second: got cycles %0d busy %b expected -1 0", cyc, busy_a);
      end
   endtask

   task automatic test_check();
      int cyc;
      logic exp_mm;
`ifdef SHIFT_LOAD_CHECK_EN
      exp_mm = 1'b1;
`else
      exp_mm = 1'b0;
`endif
      stuck = 1'b1;
      req_valid_a = 1'b1;
      req_data_a  = 8'h81;
      tick();
      req_valid_a = 1'b0;
      wait_done(1'b0, cyc);
      checks++;
      if (cyc !== 11 || result_a !== 8'h80 || mismatch_a !== exp_mm) begin
         errors++;
         $display("FAIL check_stuck: got cycles %0d result %h mismatch %b expected 11 80 %b",
                  cyc, result_a, mismatch_a, exp_mm);
      end
      stuck = 1'b0;
      req_valid_a = 1'b1;
      tick();
      req_valid_a = 1'b0;
      checks++;
      if (mismatch_a !== 1'b0) begin
         errors++;
         $display("FAIL check_clear_on_accept: got %b expected 0", mismatch_a);
      end
      wait_done(1'b0, cyc);
      checks++;
      if (cyc !== 11 || result_a !== 8'h81 || mismatch_a !== 1'b0) begin
         errors++;
         $display("FAIL check_clean: got cycles %0d result %h mismatch %b expected 11 81 0",
                  cyc, result_a, mismatch_a);
      end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_check();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
